// File: rtl/midi_parser.sv
// midi_parser: MIDI byte parser with running status driving a monophonic note/gate pair.
// Define MIDI_CHANNEL_FILTER_EN to execute only messages on CHANNEL; otherwise all channels are executed (omni).
module midi_parser #(
    parameter int CHANNEL        = 0,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_BITS   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] midi_data,
    output logic       midi_valid,
    output logic [6:0] velocity,
    output logic       note_on_pulse,
    output logic       note_off_pulse,
    output logic       err_pulse
);
    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

    localparam logic [TIMEOUT_BITS-1:0] to_last = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

    if (CHANNEL < 0 || CHANNEL > 15) begin : g_bad_channel
        $error("midi_parser: CHANNEL must be in 0..15");
    end
    if (TIMEOUT_BITS < 32 && (64'd1 << TIMEOUT_BITS) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_timeout
        $error("midi_parser: TIMEOUT_BITS too narrow for TIMEOUT_CYCLES");
    end

    state_t                  state;
    logic [7:0]              status;
    logic [6:0]              d1;
    logic                    fresh;
    logic [TIMEOUT_BITS-1:0] cnt;
    logic                    rx_ok;
    logic                    is_chan;
    logic                    is_sys;
    logic                    one_byte;
    logic                    new_one_byte;
    logic                    timing;
    logic                    timeout;
    logic                    chan_ok;

    // real-time bytes (0xF8-0xFF) are invisible to everything below
    assign rx_ok        = rx_valid && !(&rx_data[7:3]);
    assign is_chan      = rx_data[7] && rx_data[7:4] != 4'hF;
    assign is_sys       = rx_data[7:4] == 4'hF;
    assign one_byte     = status[7:4] == 4'hC || status[7:4] == 4'hD;
    assign new_one_byte = rx_data[7:4] == 4'hC || rx_data[7:4] == 4'hD;
    assign timing       = state == WAIT_D2 || (state == WAIT_D1 && fresh);
    assign timeout      = timing && !rx_ok && cnt == to_last;
`ifdef MIDI_CHANNEL_FILTER_EN
    assign chan_ok = status[3:0] == 4'(CHANNEL);
`else
    assign chan_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            status         <= '0;
            d1             <= '0;
            fresh          <= 1'b0;
            cnt            <= '0;
            midi_data      <= '0;
            midi_valid     <= 1'b0;
            velocity       <= '0;
            note_on_pulse  <= 1'b0;
            note_off_pulse <= 1'b0;
            err_pulse      <= 1'b0;
        end else begin
            note_on_pulse  <= 1'b0;
            note_off_pulse <= 1'b0;
            err_pulse      <= 1'b0;
            cnt            <= (timing && !rx_ok && !timeout) ? cnt + 1'b1 : '0;
            if (timeout) begin
                state     <= WAIT_D1;
                fresh     <= 1'b0;
                err_pulse <= 1'b1;
            end else if (rx_ok) begin
                if (is_chan) begin
                    status <= rx_data;
                    state  <= WAIT_D1;
                    fresh  <= !new_one_byte;
                end else if (is_sys) begin
                    status <= '0;
                    fresh  <= 1'b0;
                    state  <= rx_data == 8'hF0 ? SYSEX : IDLE;
                end else begin
                    case (state)
                        IDLE: err_pulse <= 1'b1;
                        WAIT_D1: begin
                            d1    <= rx_data[6:0];
                            fresh <= 1'b0;
                            state <= one_byte ? WAIT_D1 : WAIT_D2;
                        end
                        WAIT_D2: begin
                            state <= WAIT_D1;
                            if (chan_ok) begin
                                if (status[7:4] == 4'h9 && rx_data[6:0] != 7'h00) begin
                                    midi_data     <= {1'b0, d1};
                                    velocity      <= rx_data[6:0];
                                    midi_valid    <= 1'b1;
                                    note_on_pulse <= 1'b1;
                                end else if (status[7:4] == 4'h8 || status[7:4] == 4'h9) begin
                                    if (midi_valid && d1 == midi_data[6:0]) begin
                                        midi_valid     <= 1'b0;
                                        note_off_pulse <= 1'b1;
                                    end
                                end else if (status[7:4] == 4'hB && d1 == 7'h7B) begin
                                    midi_valid     <= 1'b0;
                                    note_off_pulse <= midi_valid;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_midi_parser.sv
// tb_midi_parser: table-driven byte vectors checked through a scoreboard queue, plus timeout and reset sequences.
module tb_midi_parser;
    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] midi_data;
    logic       midi_valid;
    logic [6:0] velocity;
    logic       note_on_pulse;
    logic       note_off_pulse;
    logic       err_pulse;

    midi_parser #(.CHANNEL(0), .TIMEOUT_CYCLES(TO), .TIMEOUT_BITS(8)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .midi_data(midi_data), .midi_valid(midi_valid), .velocity(velocity),
        .note_on_pulse(note_on_pulse), .note_off_pulse(note_off_pulse), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic [7:0] md;
        logic       mv;
        logic [6:0] vel;
        logic       on;
        logic       off;
        logic       err;
    } vec_t;

    typedef struct {
        string       name;
        logic [18:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   passed = 0;
    int   total = 0;

    function automatic logic [18:0] outs();
        return {midi_data, midi_valid, velocity, note_on_pulse, note_off_pulse, err_pulse};
    endfunction

    function automatic logic [18:0] pack(input vec_t v);
        return {v.md, v.mv, v.vel, v.on, v.off, v.err};
    endfunction

    task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h ({md,mv,vel,on,off,err})", name, act, exp);
    endtask

    function automatic void add(input logic [7:0] b, input logic [7:0] md, input logic mv,
                                input logic [6:0] vel, input logic on, input logic off, input logic err);
        tbl.push_back('{b, md, mv, vel, on, off, err});
    endfunction

    task automatic send(input string name, input vec_t v);
        @(negedge clk);
        sbq.push_back('{name, pack(v)});
        rx_data  = v.b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // compare one cycle after each accepted byte
    logic mon_v;
    always @(posedge clk) begin
        mon_v = rx_valid && !rst;
        #1;
        if (mon_v) begin
            if (sbq.size() == 0) chk("scoreboard_empty", outs(), '1);
            else begin
                sb_t e;
                e = sbq.pop_front();
                chk(e.name, outs(), e.exp);
            end
        end
    end

`ifdef MIDI_CHANNEL_FILTER_EN
    localparam logic [7:0] ch1_md  = 8'h47;
    localparam logic [6:0] ch1_vel = 7'h33;
    localparam logic       ch1_on  = 1'b0;
`else
    localparam logic [7:0] ch1_md  = 8'h3C;
    localparam logic [6:0] ch1_vel = 7'h64;
    localparam logic       ch1_on  = 1'b1;
`endif

    initial begin
        int waited;
        int errs;
        vec_t v;
        add(8'h90, 8'h00, 0, 7'h00, 0, 0, 0);
        add(8'h3C, 8'h00, 0, 7'h00, 0, 0, 0);
        add(8'h64, 8'h3C, 1, 7'h64, 1, 0, 0);
        add(8'h40, 8'h3C, 1, 7'h64, 0, 0, 0);
        add(8'h50, 8'h40, 1, 7'h50, 1, 0, 0);
        add(8'h3C, 8'h40, 1, 7'h50, 0, 0, 0);
        add(8'h00, 8'h40, 1, 7'h50, 0, 0, 0);
        add(8'h40, 8'h40, 1, 7'h50, 0, 0, 0);
        add(8'h00, 8'h40, 0, 7'h50, 0, 1, 0);
        add(8'h90, 8'h40, 0, 7'h50, 0, 0, 0);
        add(8'h3C, 8'h40, 0, 7'h50, 0, 0, 0);
        add(8'hF8, 8'h40, 0, 7'h50, 0, 0, 0);
        add(8'h64, 8'h3C, 1, 7'h64, 1, 0, 0);
        add(8'hB0, 8'h3C, 1, 7'h64, 0, 0, 0);
        add(8'h7B, 8'h3C, 1, 7'h64, 0, 0, 0);
        add(8'h00, 8'h3C, 0, 7'h64, 0, 1, 0);
        add(8'h7B, 8'h3C, 0, 7'h64, 0, 0, 0);
        add(8'h00, 8'h3C, 0, 7'h64, 0, 0, 0);
        add(8'hF0, 8'h3C, 0, 7'h64, 0, 0, 0);
        add(8'h3C, 8'h3C, 0, 7'h64, 0, 0, 0);
        add(8'h7F, 8'h3C, 0, 7'h64, 0, 0, 0);
        add(8'hF7, 8'h3C, 0, 7'h64, 0, 0, 0);
        add(8'h3C, 8'h3C, 0, 7'h64, 0, 0, 1);
        add(8'h64, 8'h3C, 0, 7'h64, 0, 0, 1);
        add(8'h90, 8'h3C, 0, 7'h64, 0, 0, 0);
        add(8'h45, 8'h3C, 0, 7'h64, 0, 0, 0);
        add(8'h20, 8'h45, 1, 7'h20, 1, 0, 0);
        add(8'h80, 8'h45, 1, 7'h20, 0, 0, 0);
        add(8'h46, 8'h45, 1, 7'h20, 0, 0, 0);
        add(8'h00, 8'h45, 1, 7'h20, 0, 0, 0);
        add(8'h45, 8'h45, 1, 7'h20, 0, 0, 0);
        add(8'h10, 8'h45, 0, 7'h20, 0, 1, 0);
        add(8'hC0, 8'h45, 0, 7'h20, 0, 0, 0);
        add(8'h05, 8'h45, 0, 7'h20, 0, 0, 0);
        add(8'h06, 8'h45, 0, 7'h20, 0, 0, 0);
        add(8'h90, 8'h45, 0, 7'h20, 0, 0, 0);
        add(8'h3C, 8'h45, 0, 7'h20, 0, 0, 0);
        add(8'h90, 8'h45, 0, 7'h20, 0, 0, 0);
        add(8'h47, 8'h45, 0, 7'h20, 0, 0, 0);
        add(8'h33, 8'h47, 1, 7'h33, 1, 0, 0);
        add(8'h91, 8'h47, 1, 7'h33, 0, 0, 0);
        add(8'h3C, 8'h47, 1, 7'h33, 0, 0, 0);
        add(8'h64, ch1_md, 1, ch1_vel, ch1_on, 0, 0);
        add(8'hB0, ch1_md, 1, ch1_vel, 0, 0, 0);
        add(8'h7B, ch1_md, 1, ch1_vel, 0, 0, 0);
        add(8'h00, ch1_md, 0, ch1_vel, 0, 1, 0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", outs(), '0);

        foreach (tbl[i]) send($sformatf("vec%0d_byte%h", i, tbl[i].b), tbl[i]);

        // partial message left hanging until the timeout fires
        send("to_status", '{8'h90, ch1_md, 0, ch1_vel, 0, 0, 0});
        send("to_d1", '{8'h3C, ch1_md, 0, ch1_vel, 0, 0, 0});
        waited = 0;
        errs = 0;
        for (int i = 0; i < TO + 10; i++) begin
            @(posedge clk);
            #1;
            waited = i + 1;
            if (err_pulse) begin
                errs = 1;
                break;
            end
        end
        chk("timeout_fired", 19'(errs), 19'd1);
        chk("timeout_latency", 19'(waited >= TO - 1 && waited <= TO + 1), 19'd1);
        @(posedge clk);
        #1;
        chk("timeout_err_one_cycle", {18'd0, err_pulse}, 19'd0);
        send("after_to_d1", '{8'h45, ch1_md, 0, ch1_vel, 0, 0, 0});
        send("after_to_d2", '{8'h20, 8'h45, 1, 7'h20, 1, 0, 0});

        // complete message leaves running status idle: no timeout expected
        errs = 0;
        for (int i = 0; i < TO + 5; i++) begin
            @(posedge clk);
            #1;
            if (err_pulse) errs++;
        end
        chk("no_timeout_running_status", 19'(errs), 19'd0);

        // reset wins over a completing byte in the same cycle
        send("rst_status", '{8'h90, 8'h45, 1, 7'h20, 0, 0, 0});
        send("rst_d1", '{8'h3C, 8'h45, 1, 7'h20, 0, 0, 0});
        @(negedge clk);
        rst = 1'b1;
        rx_data = 8'h64;
        rx_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_valid = 1'b0;
        chk("mid_msg_reset", outs(), '0);
        v = '{8'h40, 8'h00, 0, 7'h00, 0, 0, 1};
        send("post_reset_data_err", v);
        @(negedge clk);
        chk("scoreboard_drained", 19'(sbq.size()), 19'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/midi_parser.md
Name: midi_parser

Overview:
- Byte-level MIDI message parser that sits directly upstream of midi_player.
- Consumes raw bytes from the MIDI UART receiver (one byte per rx_valid pulse) and tracks running status.
- Decodes Note On/Off and All-Notes-Off into a monophonic note/gate pair (midi_data/midi_valid) that drives midi_player. Also emits per-event pulses for debug and LEDs.
- All other channel messages are consumed and dropped; byte alignment is preserved.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) accepted when the channel filter is compiled in.
- TIMEOUT_CYCLES, 1000000, idle clocks mid-message before a partial message is discarded.
- TIMEOUT_BITS, 20, width of the timeout counter; must satisfy 2^TIMEOUT_BITS > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- midi_data  out  8  held note number, bit7 always 0
- midi_valid  out  1  gate level, high while a note is held
- velocity  out  7  velocity of the last accepted Note On
- note_on_pulse  out  1  one-cycle pulse per accepted Note On
- note_off_pulse  out  1  one-cycle pulse when the gate falls
- err_pulse  out  1  one-cycle pulse on timeout or unexpected data byte

Behaviour:
- Reset: all outputs 0, state IDLE, running status cleared, timeout counter 0. rst has priority over rx_valid in the same cycle.
- Byte classes:
  - data: bit7 = 0
  - channel status: 0x80-0xEF
  - system common: 0xF0-0xF7
  - real-time: 0xF8-0xFF
- Real-time bytes are ignored in every state. They change neither state, running status nor the timeout counter.
- States:
  - IDLE: no running status. A data byte is dropped and pulses err_pulse. A channel status byte is latched and moves to WAIT_D1. 0xF0 moves to SYSEX. Other system common bytes stay in IDLE.
  - WAIT_D1: a data byte is latched as d1. For 0xC0/0xD0 the message is complete and the state stays in WAIT_D1; otherwise move to WAIT_D2.
  - WAIT_D2: a data byte completes the message; execute it and return to WAIT_D1 (running status).
  - SYSEX: all data bytes are discarded. 0xF7 or any other system common byte returns to IDLE. A channel status byte is latched and moves to WAIT_D1.
- In WAIT_D1/WAIT_D2, a new channel status byte replaces running status and discards any partial message; next state is WAIT_D1. A system common byte clears running status; next state is IDLE, or SYSEX for 0xF0.
- Message execution, registered: outputs change on the clock edge after the completing rx_valid cycle (1-cycle latency).
  - 0x9n with d2 != 0: midi_data <= d1, velocity <= d2, midi_valid <= 1, note_on_pulse. Retrigger or legato is allowed; the note is replaced even while the gate is high.
  - 0x8n, or 0x9n with d2 == 0: if midi_valid && d1 == midi_data[6:0], then midi_valid <= 0 and note_off_pulse; otherwise no effect. midi_data and velocity hold their values.
  - 0xBn with d1 == 0x7B (All Notes Off): midi_valid <= 0; note_off_pulse only if the gate was high.
  - All other messages have no output effect.
- Timeout:
  - The counter runs only in WAIT_D2, and in WAIT_D1 when a non-0xC/0xD status has not yet received its first data byte after a status byte. Otherwise it is held at 0.
  - It clears on any non-real-time rx_valid.
  - On reaching TIMEOUT_CYCLES: drop the partial message, go to WAIT_D1 keeping running status, and pulse err_pulse.
- Pulses are never asserted for more than one cycle. At most one of note_on_pulse/note_off_pulse is asserted per cycle.

Optional Feature:
- Macro MIDI_CHANNEL_FILTER_EN.
- Defined: channel messages whose low nibble != CHANNEL are fully parsed (state and running status advance identically) but are never executed.
- Undefined: omni mode; all 16 channels are executed and CHANNEL is unused.

Test Plan:
- Bytes 0x90 0x3C 0x64 -> one cycle after the last byte: midi_data = 0x3C, velocity = 0x64, midi_valid = 1, single note_on_pulse.
- Running status 0x90 0x3C 0x64 0x40 0x50 0x3C 0x00 -> gate moves to note 0x40. The 0x3C vel-0 Note Off is ignored (not held), so midi_valid stays 1 and there is no note_off_pulse. A following 0x40 0x00 drops the gate and pulses note_off_pulse.
- 0x90 0x3C 0xF8 0x64 -> real-time byte ignored; note on 0x3C with velocity 0x64 as if the 0xF8 were absent.
- 0xF0 0x3C 0x7F 0xF7 0x3C 0x64 -> no output change; the data byte after 0xF7 pulses err_pulse (IDLE).
- 0x90 0x3C, then no bytes for TIMEOUT_CYCLES -> err_pulse, state WAIT_D1. A following 0x45 0x20 gives note on 0x45 with velocity 0x20.
- With MIDI_CHANNEL_FILTER_EN and CHANNEL = 0: 0x91 0x3C 0x64 -> no outputs. Then 0xB0 0x7B 0x00 after a held note -> midi_valid falls with note_off_pulse. rst asserted mid-message -> all outputs 0, and the next data byte pulses err_pulse.
